// File: rtl/coeff_mult_issue.sv
// coeff_mult_issue: accepts one polynomial's worth of (a, b) coefficient pairs
// and multiplies each pair into a full-width unsigned product. Products are
// issued in order, with a marker on the last one, toward the modular reducer.
// The datapath is a 2-stage pipeline that stalls as a unit under backpressure.
module coeff_mult_issue #(
  parameter int Q       = 3329,
  parameter int N_COEFF = 256,
  parameter int DW      = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   b_i,
  output logic            prod_valid_o,
  input  logic            prod_ready_i,
  output logic [2*DW-1:0] product_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            range_err_o
);

  // One extra bit so that neither counter wraps within a polynomial.
  localparam int CW = $clog2(N_COEFF) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic            range_err_q, range_err_d;
  logic            done_q, done_d;

  // Stage 1: registered operands and last-pair tag.
  logic            s1_vld_q;
  logic [DW-1:0]   s1_a_q, s1_b_q;
  logic            s1_last_q;

  // Stage 2: registered product and last-product tag.
  logic            s2_vld_q;
  logic [2*DW-1:0] s2_prod_q;
  logic            s2_last_q;

  logic            adv;
  logic            accept;
  logic            prod_hs;
  logic            in_is_last;
  logic            out_is_last;
  logic            op_err;
  logic [2*DW-1:0] mult;

  // The whole pipeline moves when the output slot is empty or being drained.
  assign adv         = !s2_vld_q || prod_ready_i;
  assign in_ready_o  = (state_q == RUN) && adv;
  assign accept      = in_valid_i && in_ready_o;
  assign prod_hs     = s2_vld_q && prod_ready_i;
  assign in_is_last  = (in_cnt_q == CW'(N_COEFF - 1));
  assign out_is_last = (out_cnt_q == CW'(N_COEFF - 1));
  assign op_err      = (a_i >= DW'(Q)) || (b_i >= DW'(Q));
  // Zero-extend before multiplying so the full 2*DW-bit product is kept.
  assign mult        = {{DW{1'b0}}, s1_a_q} * {{DW{1'b0}}, s1_b_q};

  assign prod_valid_o = s2_vld_q;
  assign product_o    = s2_prod_q;
  assign last_o       = s2_last_q & s2_vld_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign range_err_o  = range_err_q;

  // Next-state logic for the framing FSM, counters and status flags.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    range_err_d = range_err_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = RUN;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          range_err_d = 1'b0;
        end
      end
      RUN: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + CW'(1);
          if (in_is_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (prod_hs && out_is_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && prod_hs) begin
      out_cnt_d = out_cnt_q + CW'(1);
    end
    if (accept && op_err) begin
      range_err_d = 1'b1;
    end
  end

  // Control state: FSM, counters, sticky error, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      range_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      range_err_q <= range_err_d;
      done_q      <= done_d;
    end
  end

  // Pipeline valids, tags and the visible product; reset discards in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_prod_q <= '0;
      s2_last_q <= 1'b0;
    end else if (adv) begin
      s1_vld_q  <= accept;
      s1_last_q <= accept && in_is_last;
      s2_vld_q  <= s1_vld_q;
      s2_prod_q <= mult;
      s2_last_q <= s1_last_q;
    end
  end

  // Stage-1 operand capture; qualified by s1_vld_q so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a_q <= a_i;
      s1_b_q <= b_i;
    end
  end

endmodule

// File: tb/tb_coeff_mult_issue.sv
// Directed bench for coeff_mult_issue: basic stream, backpressure with ignored
// start, max operands, range error, and mid-run asynchronous reset.
module tb_coeff_mult_issue;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [11:0] a_i;
  logic [11:0] b_i;
  logic        prod_valid_o;
  logic        prod_ready_i;
  logic [23:0] product_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;
  logic        range_err_o;

  int          checks;
  int          errors;
  int          out_idx;
  int          done_cnt;
  bit          bp_en;
  bit          held;
  logic [23:0] held_prod;
  logic        held_last;
  logic [23:0] last_prod;
  logic [11:0] ea [256];
  logic [11:0] eb [256];

  coeff_mult_issue #(.Q(3329), .N_COEFF(256), .DW(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .prod_valid_o (prod_valid_o),
    .prod_ready_i (prod_ready_i),
    .product_o    (product_o),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .range_err_o  (range_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_pair(input logic [11:0] a, input logic [11:0] b, input bit gaps);
    int  guard;
    bit  acc;
    guard = 0;
    if (gaps) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid_i = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid_i = 1'b1;
    a_i        = a;
    b_i        = b;
    forever begin
      @(negedge clk);
      acc = in_ready_o;
      @(posedge clk); #1;
      if (acc) break;
      guard++;
      if (guard > 500) begin
        chk("accept_timeout", guard, 0);
        break;
      end
    end
    in_valid_i = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) send_pair(ea[i], eb[i], gaps);
  endtask

  task automatic start_poly();
    out_idx = 0;
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int exp_done);
    int guard;
    guard = 0;
    while (done_cnt < exp_done && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("done_cnt", done_cnt, exp_done);
    chk("n_prod", out_idx, 256);
    chk("busy_after", busy_o, 0);
    chk("ready_idle", in_ready_o, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("done_single", done_cnt, exp_done);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    out_idx      = 0;
    done_cnt     = 0;
    bp_en        = 1'b0;
    held         = 1'b0;
    held_prod    = '0;
    held_last    = 1'b0;
    last_prod    = '0;
    rst_n        = 1'b0;
    start_i      = 1'b0;
    in_valid_i   = 1'b0;
    a_i          = '0;
    b_i          = '0;
    prod_ready_i = 1'b1;

    // Output-side driver: random or constant ready, changed just after each edge.
    fork
      forever begin
        @(posedge clk); #1;
        prod_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    join_none

    // Output monitor: order, values, last marker, stall stability, done pulses.
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          held = 1'b0;
          continue;
        end
        if (done_o) done_cnt++;
        if (held) begin
          chk("hold_vld", prod_valid_o, 1);
          chk("hold_prod", product_o, held_prod);
          chk("hold_last", last_o, held_last);
        end
        if (prod_valid_o && !prod_ready_i) chk("stall_ready", in_ready_o, 0);
        if (prod_valid_o && prod_ready_i) begin
          if (out_idx < 256) begin
            chk("prod", product_o, 24'(ea[out_idx]) * 24'(eb[out_idx]));
            chk("last", last_o, out_idx == 255);
            last_prod = product_o;
          end else begin
            chk("extra_prod", out_idx, 255);
          end
          out_idx++;
        end
        held      = prod_valid_o && !prod_ready_i;
        held_prod = product_o;
        held_last = last_o;
      end
    join_none

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_prod_valid", prod_valid_o, 0);
    chk("rst_product", product_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_range_err", range_err_o, 0);
    rst_n = 1'b1;

    // Basic: a=i, b=i+1, no backpressure, two-cycle latency.
    for (int i = 0; i < 256; i++) begin
      ea[i] = 12'(i);
      eb[i] = 12'(i + 1);
    end
    start_poly();
    chk("busy_run", busy_o, 1);
    send_pair(ea[0], eb[0], 1'b0);
    chk("lat1_vld", prod_valid_o, 0);
    send_pair(ea[1], eb[1], 1'b0);
    chk("lat2_vld", prod_valid_o, 1);
    send_range(2, 255, 1'b0);
    wait_done(1);
    chk("basic_last_prod", last_prod, 65280);
    chk("basic_range_err", range_err_o, 0);

    // Idle input ignored, then backpressure with a start pulse mid-run.
    in_valid_i = 1'b1;
    a_i        = 12'd5;
    b_i        = 12'd5;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_ready", in_ready_o, 0);
      chk("idle_prod_vld", prod_valid_o, 0);
    end
    in_valid_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ea[i] = 12'($urandom_range(0, 3328));
      eb[i] = 12'($urandom_range(0, 3328));
    end
    bp_en = 1'b1;
    start_poly();
    send_range(0, 49, 1'b1);
    start_i = 1'b1;
    send_range(50, 50, 1'b1);
    start_i = 1'b0;
    send_range(51, 255, 1'b1);
    wait_done(2);
    bp_en = 1'b0;

    // Maximum operands.
    for (int i = 0; i < 256; i++) begin
      ea[i] = 12'd3328;
      eb[i] = 12'd3328;
    end
    start_poly();
    send_range(0, 255, 1'b0);
    wait_done(3);
    chk("max_prod", last_prod, 11075584);
    chk("max_mod", last_prod % 3329, 1);

    // Range error on pair 17; product still issued; sticky through done.
    for (int i = 0; i < 256; i++) begin
      ea[i] = 12'(i + 3);
      eb[i] = 12'(2 * i + 1);
    end
    ea[17] = 12'd3329;
    start_poly();
    send_range(0, 16, 1'b0);
    chk("rerr_before", range_err_o, 0);
    send_range(17, 17, 1'b0);
    chk("rerr_set", range_err_o, 1);
    send_range(18, 255, 1'b0);
    wait_done(4);
    chk("rerr_sticky", range_err_o, 1);

    // Next start clears the error; async reset at in_cnt=100 under backpressure.
    for (int i = 0; i < 256; i++) begin
      ea[i] = 12'((i * 7) % 3329);
      eb[i] = 12'(255 - i);
    end
    start_poly();
    chk("rerr_cleared", range_err_o, 0);
    bp_en = 1'b1;
    send_range(0, 99, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_in_ready", in_ready_o, 0);
    chk("ar_prod_valid", prod_valid_o, 0);
    chk("ar_product", product_o, 0);
    chk("ar_last", last_o, 0);
    chk("ar_busy", busy_o, 0);
    chk("ar_done", done_o, 0);
    chk("ar_range_err", range_err_o, 0);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("ar_no_done", done_cnt, 4);
    chk("ar_idle_vld", prod_valid_o, 0);

    // Clean polynomial after reset.
    for (int i = 0; i < 256; i++) begin
      ea[i] = 12'(255 - i);
      eb[i] = 12'(i);
    end
    start_poly();
    send_range(0, 255, 1'b0);
    wait_done(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
